// File: rtl/riscv_mem_pkg.sv
// Shared MEM-stage definitions: funct3 codes, load result source, FSM states
// and the byte-enable helper.
package riscv_mem_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [1:0] RSRC_LOAD = 2'b01;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   // Byte, halfword (lane pair picked by a[1]) or full word; 011/110/111 fall into word.
   function automatic logic [3:0] be_for(input logic [2:0] funct3, input logic [1:0] a);
      logic [3:0] be;
      case (funct3)
         F3_LB, F3_LBU: be = 4'b0001 << a;
         F3_LH, F3_LHU: be = 4'b0011 << {a[1], 1'b0};
         default:       be = 4'hF;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed lane of a read word and sign/zero-extends it by funct3.
module load_extend
   import riscv_mem_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  a_i,
   output logic [31:0] result_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v   = rdata_i[{a_i, 3'b000} +: 8];
      half_v   = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      result_o = '0;
      case (funct3_i)
         F3_LB:   result_o = {{24{byte_v[7]}}, byte_v};
         F3_LH:   result_o = {{16{half_v[15]}}, half_v};
         F3_LW:   result_o = rdata_i;
         F3_LBU:  result_o = {24'h0, byte_v};
         F3_LHU:  result_o = {16'h0, half_v};
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: turns load/store control into a req/ready bus transaction and
// stalls the front pipeline until it completes. Optional: MISALIGN_TRAP_EN.
module mem_stage_ctrl
   import riscv_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter int unsigned TO_W        = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memWrite_MEM,
   input  logic [1:0]  resultSrc_MEM,
   input  logic [2:0]  funct3_MEM,
   input  logic [31:0] ALUResult_MEM,
   input  logic [31:0] storeOut_MEM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        stall_MEM,
   output logic [31:0] readData_MEM,
   output logic        bus_err
`ifdef MISALIGN_TRAP_EN
   ,
   output logic        misalign_trap
`endif
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   state_e            state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        be_q, be_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [1:0]        a_q, a_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [TO_W-1:0]   cnt_q, cnt_d;
   logic              access;
   logic              timeout_hit;
   logic [31:0]       ext_data;

`ifdef MISALIGN_TRAP_EN
   logic trap_q, trap_d;
   logic misaligned;

   assign misaligned = ((funct3_MEM[1:0] == 2'b01) && ALUResult_MEM[0]) ||
                       (funct3_MEM[1] && (ALUResult_MEM[1:0] != 2'b00));
   assign misalign_trap = trap_q;
`endif

   assign access      = memWrite_MEM | (resultSrc_MEM == RSRC_LOAD);
   assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

   load_extend u_load_extend (
      .rdata_i  (dmem_rdata),
      .funct3_i (funct3_q),
      .a_i      (a_q),
      .result_o (ext_data)
   );

   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      funct3_d = funct3_q;
      a_d      = a_q;
      rdata_d  = rdata_q;
      cnt_d    = cnt_q;
      err_d    = 1'b0;
`ifdef MISALIGN_TRAP_EN
      trap_d   = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (access) begin
               we_d     = memWrite_MEM;
               addr_d   = {ALUResult_MEM[31:2], 2'b00};
               wdata_d  = storeOut_MEM;
               be_d     = be_for(funct3_MEM, ALUResult_MEM[1:0]);
               funct3_d = funct3_MEM;
               a_d      = ALUResult_MEM[1:0];
               state_d  = BUSY;
               req_d    = 1'b1;
`ifdef MISALIGN_TRAP_EN
               if (misaligned) begin
                  state_d = DONE;
                  req_d   = 1'b0;
                  trap_d  = 1'b1;
                  rdata_d = '0;
               end
`endif
            end
         end
         BUSY: begin
            // Ready wins over a timeout landing in the same cycle.
            if (dmem_ready) begin
               state_d = DONE;
               req_d   = 1'b0;
               if (!we_q) rdata_d = ext_data;
            end else if (timeout_hit) begin
               state_d = DONE;
               req_d   = 1'b0;
               err_d   = 1'b1;
               rdata_d = '0;
            end else if (TIMEOUT_CYC != 0) begin
               cnt_d = cnt_q + TO_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         funct3_q <= '0;
         a_q      <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
`ifdef MISALIGN_TRAP_EN
         trap_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         funct3_q <= funct3_d;
         a_q      <= a_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
`ifdef MISALIGN_TRAP_EN
         trap_q   <= trap_d;
`endif
      end
   end

   assign dmem_req     = req_q;
   assign dmem_we      = we_q;
   assign dmem_addr    = addr_q;
   assign dmem_wdata   = wdata_q;
   assign dmem_be      = be_q;
   assign readData_MEM = rdata_q;
   assign bus_err      = err_q;
   assign stall_MEM    = access & (state_q != DONE);

endmodule
